// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the datapath controller and the multicycle ALU.
// The controller drives operands and start; the ALU returns status and results.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [3:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] rd_hi;
  logic             dz;

  modport master (
    output start, rs, rt, op,
    input  busy, done, rd, rd_hi, dz
  );

  modport slave (
    input  start, rs, rt, op,
    output busy, done, rd, rd_hi, dz
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle unsigned ALU: single-cycle add/sub, iterative shift-add
// multiply and restoring divide with a start/busy/done handshake.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  multicycle_alu_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNTW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_rd;
  logic [WIDTH-1:0]   r_rd_hi;
  logic               r_dz;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_sub;
  logic               w_is_div;
  logic               w_dz;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_part;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_step;
  logic               w_last;

  assign w_accept = bus.start &&
                    (r_state == IDLE || r_state == FIN);
  assign w_is_mul = (bus.op == 4'b0010);
  assign w_is_sub = (bus.op == 4'b0100);
  assign w_is_div = (bus.op == 4'b0001);
  assign w_dz     = w_is_div && (bus.rt == '0);
  assign w_last   = (r_cnt == CNTW'(1));

  // One iteration of either engine; r_acc low half holds the
  // dividend/quotient during DIV, the product low bits during MUL.
  always_comb begin
    w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
             {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};
    w_part = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff = w_part - {1'b0, r_a};
    w_step = '0;
    if (r_state == MUL) begin
      w_step = {w_msum, r_acc[WIDTH-1:1]};
    end else begin
      w_step = {(w_diff[WIDTH] ? w_part[WIDTH-1:0]
                               : w_diff[WIDTH-1:0]),
                r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, FIN: begin
        if (!w_accept)     w_next = IDLE;
        else if (w_is_mul) w_next = MUL;
        else if (w_is_div && !w_dz) w_next = DIV;
        else               w_next = FIN;
      end
      MUL, DIV: if (w_last) w_next = FIN;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == MUL) || (r_state == DIV);
    bus.done = (r_state == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_rd_hi <= '0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.rt;
      r_b   <= bus.rt;
      r_cnt <= CNTW'(WIDTH);
      if (w_is_mul) begin
        r_a   <= bus.rs;
        r_acc <= '0;
      end else if (w_dz) begin
        r_rd    <= '1;
        r_rd_hi <= bus.rs;
        r_dz    <= 1'b1;
      end else if (w_is_div) begin
        r_acc <= {{WIDTH{1'b0}}, bus.rs};
      end else begin
        r_rd    <= w_is_sub ? bus.rs - bus.rt : bus.rs + bus.rt;
        r_rd_hi <= '0;
        r_dz    <= 1'b0;
      end
    end else if (r_state == MUL || r_state == DIV) begin
      r_acc <= w_step;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CNTW'(1);
      // Final iteration lands straight in the result registers.
      if (w_last) begin
        r_rd    <= w_step[WIDTH-1:0];
        r_rd_hi <= w_step[2*WIDTH-1:WIDTH];
        r_dz    <= 1'b0;
      end
    end
  end

  assign bus.rd    = r_rd;
  assign bus.rd_hi = r_rd_hi;
  assign bus.dz    = r_dz;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: latency, results, busy behaviour,
// ignored starts, back-to-back issue and mid-operation reset.
module tb_multicycle_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total = 0;
  int cyc;
  int bcyc;
  int dseen;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.rs = a;
    bus.rt = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    bcyc = 0;
  endtask

  task automatic wait_done();
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) bcyc++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 4'b0000;
    bus.rs = '0;
    bus.rt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rd", 64'(bus.rd), 64'd0);
    chk("rst_rd_hi", 64'(bus.rd_hi), 64'd0);
    chk("rst_dz", 64'(bus.dz), 64'd0);

    launch(4'b1000, 32'd7, 32'd5);
    wait_done();
    chk("add_lat", 64'(cyc), 64'd1);
    chk("add_busy", 64'(bcyc), 64'd0);
    chk("add_rd", 64'(bus.rd), 64'd12);
    chk("add_rd_hi", 64'(bus.rd_hi), 64'd0);
    chk("add_dz", 64'(bus.dz), 64'd0);
    @(posedge clk);
    #1;
    chk("add_done_pulse", 64'(bus.done), 64'd0);
    chk("add_hold", 64'(bus.rd), 64'd12);

    launch(4'b0100, 32'd3, 32'd5);
    wait_done();
    chk("sub_lat", 64'(cyc), 64'd1);
    chk("sub_rd", 64'(bus.rd), 64'hFFFF_FFFE);

    launch(4'b0110, 32'd2, 32'd2);
    wait_done();
    chk("dflt_rd", 64'(bus.rd), 64'd4);

    launch(4'b1000, 32'hFFFF_FFFF, 32'd1);
    wait_done();
    chk("add_wrap", 64'(bus.rd), 64'd0);

    launch(4'b0010, 32'hFFFF_FFFF, 32'd2);
    wait_done();
    chk("mul_lat", 64'(cyc), 64'd33);
    chk("mul_busy", 64'(bcyc), 64'd32);
    chk("mul_rd", 64'(bus.rd), 64'hFFFF_FFFE);
    chk("mul_rd_hi", 64'(bus.rd_hi), 64'd1);

    launch(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    chk("mulmax", {bus.rd_hi, bus.rd}, 64'hFFFF_FFFE_0000_0001);

    launch(4'b0001, 32'd100, 32'd7);
    wait_done();
    chk("div_lat", 64'(cyc), 64'd33);
    chk("div_rd", 64'(bus.rd), 64'd14);
    chk("div_rd_hi", 64'(bus.rd_hi), 64'd2);
    chk("div_dz", 64'(bus.dz), 64'd0);

    launch(4'b0001, 32'hFFFF_FFFF, 32'd1);
    wait_done();
    chk("div1", {bus.rd_hi, bus.rd}, 64'h0000_0000_FFFF_FFFF);

    launch(4'b0001, 32'd5, 32'd0);
    wait_done();
    chk("dz_lat", 64'(cyc), 64'd1);
    chk("dz_rd", 64'(bus.rd), 64'hFFFF_FFFF);
    chk("dz_rd_hi", 64'(bus.rd_hi), 64'd5);
    chk("dz_flag", 64'(bus.dz), 64'd1);

    // A start while busy must be dropped and the operands it carries ignored.
    launch(4'b0010, 32'd6, 32'd7);
    while (cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b1;
    bus.op = 4'b1000;
    bus.rs = 32'd1;
    bus.rt = 32'd1;
    @(posedge clk);
    #1;
    cyc++;
    bus.start = 1'b0;
    bus.rs = 32'd9;
    bus.rt = 32'd9;
    chk("ign_busy", 64'(bus.busy), 64'd1);
    wait_done();
    chk("ign_lat", 64'(cyc), 64'd33);
    chk("ign_rd", 64'(bus.rd), 64'd42);
    chk("ign_rd_hi", 64'(bus.rd_hi), 64'd0);
    chk("ign_dz", 64'(bus.dz), 64'd0);

    bus.start = 1'b1;
    bus.op = 4'b1000;
    bus.rs = 32'd1;
    bus.rt = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_done", 64'(bus.done), 64'd1);
    chk("b2b_rd", 64'(bus.rd), 64'd2);

    launch(4'b0001, 32'd100, 32'd7);
    while (cyc < 15) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_rd", 64'(bus.rd), 64'd0);
    chk("mrst_rd_hi", 64'(bus.rd_hi), 64'd0);
    chk("mrst_dz", 64'(bus.dz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dseen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dseen++;
    end
    chk("mrst_no_done", 64'(dseen), 64'd0);

    launch(4'b1000, 32'd1, 32'd1);
    wait_done();
    chk("post_rst_lat", 64'(cyc), 64'd1);
    chk("post_rst_rd", 64'(bus.rd), 64'd2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
